o41ai_bist: RTL and testbench
=============================

# o41ai_bist

Self-test stage wrapped around one scs8hd_o41ai_1 instance. It is the block directly upstream of the cell's inputs A1–A4 and B1 and directly downstream of its output Y. It walks all 32 input vectors, waits a programmable settle time, samples Y, and compares it with Y = ~(B1 & (A1|A2|A3|A4)). It reports pass/fail, a saturating error count and the first failing vector. It is used in silicon bring-up and in gate-level regression of the cell library.

## Interface
Parameters:
- SETTLE_CYCLES, 2 — wait cycles between applying a vector and sampling Y; legal range 1..15.
- CNT_W, 6 — width of ERR_CNT; minimum 6, so all 32 vectors can be counted.

Ports:
- CLK  input  1  — single clock; all state changes on the rising edge.
- RESET  input  1  — asynchronous, active-high reset.
- START  input  1  — begin a run; sampled only in IDLE and DONE.
- A1, A2, A3, A4, B1  output  1 each  — registered drive to the cell under test.
- Y  input  1  — cell output, sampled in SAMPLE.
- BUSY  output  1  — high in APPLY, WAIT and SAMPLE.
- DONE  output  1  — high in DONE state.
- PASS  output  1  — DONE & (ERR_CNT == 0).
- ERR_CNT  output  CNT_W  — count of mismatches; saturates at all-ones.
- FAIL_VALID  output  1  — at least one mismatch seen this run.
- FIRST_FAIL  output  5  — vector index of the first mismatch; valid when FAIL_VALID.
- SIGNATURE  output  16  — MISR of sampled Y; present only with O41AI_BIST_MISR_EN.

## Operation
- Vector index v[4:0] maps to {B1,A4,A3,A2,A1}. The sequence is ascending, 0 to 31.
- States and transitions:
  - IDLE → APPLY on START. This clears ERR_CNT, FAIL_VALID and FIRST_FAIL, and sets v = 0.
  - APPLY drives v onto the pins and loads the settle counter with SETTLE_CYCLES, then → WAIT.
  - WAIT decrements the settle counter and → SAMPLE when it reaches 1.
  - SAMPLE compares Y with the expected value.
  - From SAMPLE: if v == 31 → DONE; otherwise v++ and → APPLY.
  - DONE → APPLY on START, restarting with the same clearing as IDLE → APPLY.
- Mismatch rule: Y !== expected. An X or Z on Y counts as a mismatch.
  - Each mismatch increments ERR_CNT, which holds once it reaches 2^CNT_W−1.
  - The first mismatch of a run sets FAIL_VALID and records v in FIRST_FAIL. Later mismatches do not change FIRST_FAIL.
- A fault-free cell gives 15 vectors with Y=0 (B1=1, any A set) and 17 vectors with Y=1.
- START is ignored while BUSY; there is no abort.
- Pins hold their last vector (31) in DONE. They return to 0 only on reset.

## Timing
- Reset values: all outputs 0, state IDLE, v = 0. SIGNATURE resets to 16'hFFFF.
- RESET asserted mid-run forces the reset values immediately, and the partial run is discarded. After release the block waits in IDLE for START.
- Each vector occupies SETTLE_CYCLES+2 cycles: 1 APPLY, SETTLE_CYCLES WAIT, 1 SAMPLE.
- Call the START-sampling edge E0. DONE rises on edge E0 + 32·(SETTLE_CYCLES+2). With the default this is E0+128.
- ERR_CNT, FAIL_VALID and FIRST_FAIL update on the edge that leaves SAMPLE. They are stable throughout DONE.
- Pins change only on the edge entering APPLY, so Y has SETTLE_CYCLES+1 full cycles to settle before it is sampled.
- START high in DONE on the same cycle RESET deasserts is ignored; reset wins.

## Configuration
- Macro: O41AI_BIST_MISR_EN.
- Defined: the SIGNATURE port and a 16-bit MISR are present.
  - The MISR is seeded to 16'hFFFF on START.
  - Each SAMPLE it updates as sig ← {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^Y}.
  - X on Y propagates into the signature.
- Undefined: no SIGNATURE port, and no MISR logic or flops. All other behaviour is identical.

## Structure
- Package o41ai_bist_pkg holds:
  - the state enum (IDLE, APPLY, WAIT, SAMPLE, DONE);
  - VEC_W = 5 and NUM_VEC = 32;
  - MISR_SEED = 16'hFFFF and the MISR tap mask;
  - the expected-Y function of v.
- Sub-module o41ai_bist_misr holds the signature register, enable and seed. It is instantiated only under O41AI_BIST_MISR_EN.
- The top holds the FSM, the vector counter, the settle counter and the error bookkeeping.

## Test plan
- Good cell, SETTLE_CYCLES=2, START pulse → DONE at E0+128, PASS=1, ERR_CNT=0, FAIL_VALID=0, and pins equal 5'b11111 in DONE.
- Y stuck at 1 → ERR_CNT=15, FIRST_FAIL=17 (B1=1, A1=1), PASS=0.
- Y stuck at 0 → ERR_CNT=17, FIRST_FAIL=0. Repeat with CNT_W=4 → ERR_CNT saturates at 15.
- RESET asserted at E0+50 → all outputs 0 within the reset edge. A new START then gives a clean PASS at E0'+128.
- START pulsed during BUSY and again in DONE → the first is ignored. The second restarts: counters clear, and DONE falls on the next edge.
- With O41AI_BIST_MISR_EN, good cell → SIGNATURE equals the bench model value. Flipping Y for v=5 changes SIGNATURE and gives ERR_CNT=1, FIRST_FAIL=5.

Source files
------------

// File: rtl/o41ai_bist_pkg.sv
// o41ai_bist_pkg: shared states, vector constants, MISR constants and golden model of the o41ai cell
package o41ai_bist_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_APPLY, ST_WAIT, ST_SAMPLE, ST_DONE} state_t;
  localparam int VEC_W = 5;
  localparam int NUM_VEC = 32;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam logic [15:0] MISR_TAPS = 16'hB400;
  function automatic logic exp_y(input logic [VEC_W-1:0] v);
    return ~(v[4] & |v[3:0]);
  endfunction
endpackage

// File: rtl/o41ai_bist_misr.sv
// o41ai_bist_misr: 16-bit MISR compressing sampled Y, seeded at run start
module o41ai_bist_misr
  import o41ai_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed,
  input  logic        en,
  input  logic        y,
  output logic [15:0] sig
);
  // shift in tap parity xor Y on every sample; X on Y deliberately propagates
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= MISR_SEED;
    else if (seed) sig <= MISR_SEED;
    else if (en) sig <= {sig[14:0], ^(sig & MISR_TAPS) ^ y};
endmodule

// File: rtl/o41ai_bist.sv
// o41ai_bist: exhaustive self-test of one o41ai cell; optional signature with O41AI_BIST_MISR_EN
module o41ai_bist
  import o41ai_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             A4,
  output logic             B1,
  input  logic             Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
`ifdef O41AI_BIST_MISR_EN
  output logic [4:0]       FIRST_FAIL,
  output logic [15:0]      SIGNATURE
`else
  output logic [4:0]       FIRST_FAIL
`endif
);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  state_t state_q, state_d;
  logic [VEC_W-1:0] v_q;
  logic [3:0] cnt_q;
  logic start_go, sample, miss;
  assign start_go = START && (state_q == ST_IDLE || state_q == ST_DONE);
  assign sample = state_q == ST_SAMPLE;
  assign miss = sample && (Y !== exp_y(v_q));
  assign {B1, A4, A3, A2, A1} = v_q;
  assign BUSY = state_q == ST_APPLY || state_q == ST_WAIT || state_q == ST_SAMPLE;
  assign DONE = state_q == ST_DONE;
  assign PASS = DONE && ERR_CNT == '0;
  // next-state: walk APPLY/WAIT/SAMPLE per vector until the last one is sampled
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = START ? ST_APPLY : state_q;
      ST_APPLY:         state_d = ST_WAIT;
      ST_WAIT:          state_d = (cnt_q == 4'd1) ? ST_SAMPLE : ST_WAIT;
      ST_SAMPLE:        state_d = (v_q == LAST_VEC) ? ST_DONE : ST_APPLY;
      default:          state_d = ST_IDLE;
    endcase
  end
  // state, vector (which is also the pin drive), settle counter and error bookkeeping
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      v_q <= '0;
      cnt_q <= '0;
      ERR_CNT <= '0;
      FAIL_VALID <= 1'b0;
      FIRST_FAIL <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_APPLY) cnt_q <= 4'(SETTLE_CYCLES);
      else if (state_q == ST_WAIT) cnt_q <= cnt_q - 4'd1;
      if (start_go) begin
        v_q <= '0;
        ERR_CNT <= '0;
        FAIL_VALID <= 1'b0;
        FIRST_FAIL <= '0;
      end
      if (sample && v_q != LAST_VEC) v_q <= v_q + 1'b1;
      if (miss && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
      if (miss && !FAIL_VALID) begin
        FAIL_VALID <= 1'b1;
        FIRST_FAIL <= v_q;
      end
    end
  end
`ifdef O41AI_BIST_MISR_EN
  o41ai_bist_misr u_misr (
    .clk (CLK),
    .rst (RESET),
    .seed(start_go),
    .en  (sample),
    .y   (Y),
    .sig (SIGNATURE)
  );
`endif
endmodule

// File: tb/tb_o41ai_bist.sv
// tb_o41ai_bist: directed bench for o41ai_bist with a behavioural cell model and fault modes
module tb_o41ai_bist;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic a1, a2, a3, a4, b1, y, busy, done, pass, fv;
  logic [5:0] err;
  logic [4:0] ff, pins;
  logic b4_a1, b4_a2, b4_a3, b4_a4, b4_b1, b4_busy, b4_done, b4_pass, b4_fv;
  logic [3:0] b4_err;
  logic [4:0] b4_ff;
  int mode = 0;
  int tests = 0, fails = 0;
`ifdef O41AI_BIST_MISR_EN
  logic [15:0] sig, b4_sig;
`endif
  always #5 clk = ~clk;
  assign pins = {b1, a4, a3, a2, a1};
  assign y = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 :
             (~(b1 & (a1 | a2 | a3 | a4))) ^ (mode == 3 && pins == 5'd5);

  o41ai_bist dut (
    .CLK(clk), .RESET(rst), .START(start), .A1(a1), .A2(a2), .A3(a3), .A4(a4), .B1(b1),
    .Y(y), .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err), .FAIL_VALID(fv),
`ifdef O41AI_BIST_MISR_EN
    .FIRST_FAIL(ff), .SIGNATURE(sig)
`else
    .FIRST_FAIL(ff)
`endif
  );

  o41ai_bist #(.CNT_W(4)) dut4 (
    .CLK(clk), .RESET(rst), .START(start), .A1(b4_a1), .A2(b4_a2), .A3(b4_a3), .A4(b4_a4),
    .B1(b4_b1), .Y(y), .BUSY(b4_busy), .DONE(b4_done), .PASS(b4_pass), .ERR_CNT(b4_err),
    .FAIL_VALID(b4_fv),
`ifdef O41AI_BIST_MISR_EN
    .FIRST_FAIL(b4_ff), .SIGNATURE(b4_sig)
`else
    .FIRST_FAIL(b4_ff)
`endif
  );

  function automatic logic [15:0] misr_model(input int flip);
    logic [15:0] s;
    logic [4:0] v;
    logic yy;
    s = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      yy = ~(v[4] & |v[3:0]) ^ (i == flip);
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ yy};
    end
    return s;
  endfunction

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if ({pins, busy, done, pass, fv} !== 9'd0) begin fails++; $display("FAIL reset_bits got %b want 0", {pins, busy, done, pass, fv}); end
    tests++; if (err !== 6'd0) begin fails++; $display("FAIL reset_err got %0d want 0", err); end
    tests++; if (ff !== 5'd0) begin fails++; $display("FAIL reset_ff got %0d want 0", ff); end
`ifdef O41AI_BIST_MISR_EN
    tests++; if (sig !== 16'hFFFF) begin fails++; $display("FAIL reset_sig got %h want ffff", sig); end
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL idle_no_start got %b want 00", {busy, done}); end
  endtask

  task automatic test_good();
    int n;
    mode = 0;
    start_run();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL good_busy got %b want 1", busy); end
    wait_done(n);
    tests++; if (n !== 128) begin fails++; $display("FAIL good_latency got %0d want 128", n); end
    tests++; if ({pass, fv, busy} !== 3'b100) begin fails++; $display("FAIL good_flags got %b want 100", {pass, fv, busy}); end
    tests++; if (err !== 6'd0) begin fails++; $display("FAIL good_err got %0d want 0", err); end
    tests++; if (pins !== 5'b11111) begin fails++; $display("FAIL good_pins got %b want 11111", pins); end
  endtask

  task automatic test_stuck1();
    int n;
    mode = 1;
    start_run();
    wait_done(n);
    tests++; if (err !== 6'd15) begin fails++; $display("FAIL s1_err got %0d want 15", err); end
    tests++; if (ff !== 5'd17) begin fails++; $display("FAIL s1_first got %0d want 17", ff); end
    tests++; if ({pass, fv} !== 2'b01) begin fails++; $display("FAIL s1_flags got %b want 01", {pass, fv}); end
  endtask

  task automatic test_stuck0();
    int n;
    mode = 2;
    start_run();
    wait_done(n);
    tests++; if (err !== 6'd17) begin fails++; $display("FAIL s0_err got %0d want 17", err); end
    tests++; if (ff !== 5'd0 || fv !== 1'b1) begin fails++; $display("FAIL s0_first got %0d/%b want 0/1", ff, fv); end
    tests++; if (b4_err !== 4'd15) begin fails++; $display("FAIL s0_sat got %0d want 15", b4_err); end
    tests++; if (b4_done !== 1'b1 || b4_pass !== 1'b0) begin fails++; $display("FAIL s0_sat_flags got %b want 10", {b4_done, b4_pass}); end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 1;
    start_run();
    repeat (49) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if ({pins, busy, done, pass, fv} !== 9'd0 || err !== 6'd0 || ff !== 5'd0) begin fails++; $display("FAIL midreset got %b/%0d/%0d want 0", {pins, busy, done, pass, fv}, err, ff); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL midreset_idle got %b want 00", {busy, done}); end
    mode = 0;
    start_run();
    wait_done(n);
    tests++; if (n !== 128 || pass !== 1'b1) begin fails++; $display("FAIL midreset_rerun got %0d/%b want 128/1", n, pass); end
  endtask

  task automatic test_back_to_back();
    int n;
    mode = 1;
    start_run();
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1 n++;
      start = (n == 20);
    end
    start = 1'b0;
    tests++; if (n !== 128 || err !== 6'd15) begin fails++; $display("FAIL busy_start got %0d/%0d want 128/15", n, err); end
    mode = 0;
    start_run();
    tests++; if ({done, busy, fv} !== 3'b010 || err !== 6'd0 || ff !== 5'd0) begin fails++; $display("FAIL restart_clear got %b/%0d/%0d want 010/0/0", {done, busy, fv}, err, ff); end
    tests++; if (pins !== 5'd0) begin fails++; $display("FAIL restart_pins got %b want 00000", pins); end
    wait_done(n);
    tests++; if (n !== 128 || pass !== 1'b1) begin fails++; $display("FAIL restart_run got %0d/%b want 128/1", n, pass); end
  endtask

`ifdef O41AI_BIST_MISR_EN
  task automatic test_misr();
    int n;
    logic [15:0] good;
    mode = 0;
    good = misr_model(-1);
    start_run();
    wait_done(n);
    tests++; if (sig !== good) begin fails++; $display("FAIL misr_good got %h want %h", sig, good); end
    mode = 3;
    start_run();
    wait_done(n);
    tests++; if (sig !== misr_model(5) || sig === good) begin fails++; $display("FAIL misr_flip got %h want %h", sig, misr_model(5)); end
    tests++; if (err !== 6'd1 || ff !== 5'd5) begin fails++; $display("FAIL misr_flip_err got %0d/%0d want 1/5", err, ff); end
  endtask
`endif

  initial begin
    test_reset();
    test_good();
    test_stuck1();
    test_stuck0();
    test_reset_mid();
    test_back_to_back();
`ifdef O41AI_BIST_MISR_EN
    test_misr();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
